// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller.
// Tags and line data live in an external single-port BRAM. Valid bits are kept here
// so that a flush can invalidate every line in a single cycle.
module icache_controller #(
    parameter int TAG_WIDTH   = 20,
    parameter int INDEX_WIDTH = 8,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    // core side
    input  logic                             req_valid_i,
    input  logic [31:0]                      req_addr_i,
    output logic                             req_ready_o,
    output logic                             resp_valid_o,
    output logic [31:0]                      resp_instr_o,
    input  logic                             flush_i,
    // memory side
    output logic                             mem_req_valid_o,
    output logic [31:0]                      mem_req_addr_o,
    input  logic                             mem_req_ready_i,
    input  logic                             mem_resp_valid_i,
    input  logic [BLOCK_WIDTH-1:0]           mem_resp_data_i,
    // BRAM side
    output logic                             bram_cmd_en_o,
    output logic                             bram_wr_en_o,
    output logic [INDEX_WIDTH-1:0]           bram_addr_o,
    output logic [TAG_WIDTH+BLOCK_WIDTH-1:0] bram_data_o,
    input  logic [TAG_WIDTH+BLOCK_WIDTH-1:0] bram_data_i,
    // status
    output logic                             busy_o
);

    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int WORD_W = TAG_WIDTH + BLOCK_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_REFILL
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [BLOCK_WIDTH-1:0] line_q, line_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic                   flush_pend_q, flush_pend_d;

    logic [TAG_WIDTH-1:0]   cur_tag;
    logic [INDEX_WIDTH-1:0] cur_idx;
    logic [INDEX_WIDTH-1:0] req_idx;
    logic [1:0]             cur_word;
    logic                   unused_addr_bits;

    assign cur_tag          = addr_q[31 -: TAG_WIDTH];
    assign cur_idx          = addr_q[INDEX_WIDTH+3:4];
    assign cur_word         = addr_q[3:2];
    assign req_idx          = req_addr_i[INDEX_WIDTH+3:4];
    // byte offset within the fetched word has no effect on the response
    assign unused_addr_bits = ^addr_q[1:0];

    // pick 32-bit word sel out of a line, word 0 in the least significant bits
    function automatic logic [31:0] word_sel(input logic [BLOCK_WIDTH-1:0] line,
                                             input logic [1:0]             sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

    // state register plus latched request, captured fill line and valid array
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            line_q       <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // next-state, datapath updates and all outputs; everything forced low in reset
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        line_d          = line_q;
        valid_d         = valid_q;
        flush_pend_d    = flush_pend_q;
        req_ready_o     = 1'b0;
        resp_valid_o    = 1'b0;
        resp_instr_o    = '0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        bram_cmd_en_o   = 1'b0;
        bram_wr_en_o    = 1'b0;
        bram_addr_o     = '0;
        bram_data_o     = '0;
        busy_o          = (state_q != S_IDLE);

        // a flush arriving mid-access is remembered and applied once back in IDLE
        if (state_q != S_IDLE && flush_i) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                req_ready_o = !flush_i && !flush_pend_q;
                if (flush_i || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (req_valid_i) begin
                    addr_d        = req_addr_i;
                    bram_cmd_en_o = 1'b1;
                    bram_addr_o   = req_idx;
                    state_d       = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (valid_q[cur_idx] && bram_data_i[WORD_W-1:BLOCK_WIDTH] == cur_tag) begin
                    resp_valid_o = 1'b1;
                    resp_instr_o = word_sel(bram_data_i[BLOCK_WIDTH-1:0], cur_word);
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {addr_q[31:4], 4'h0};
                if (mem_req_ready_i) begin
                    state_d = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                if (mem_resp_valid_i) begin
                    line_d  = mem_resp_data_i;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                bram_cmd_en_o    = 1'b1;
                bram_wr_en_o     = 1'b1;
                bram_addr_o      = cur_idx;
                bram_data_o      = {cur_tag, line_q};
                valid_d[cur_idx] = 1'b1;
                resp_valid_o     = 1'b1;
                resp_instr_o     = word_sel(line_q, cur_word);
                state_d          = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!rst_ni) begin
            req_ready_o     = 1'b0;
            resp_valid_o    = 1'b0;
            resp_instr_o    = '0;
            mem_req_valid_o = 1'b0;
            mem_req_addr_o  = '0;
            bram_cmd_en_o   = 1'b0;
            bram_wr_en_o    = 1'b0;
            bram_addr_o     = '0;
            bram_data_o     = '0;
            busy_o          = 1'b0;
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// Randomized scoreboard bench for icache_controller with a BRAM model, a memory
// responder and a line-level reference model of the cache contents.
module tb_icache_controller;

    localparam int TW = 20;
    localparam int IW = 8;
    localparam int BW = 128;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            req_valid_i;
    logic [31:0]     req_addr_i;
    logic            req_ready_o;
    logic            resp_valid_o;
    logic [31:0]     resp_instr_o;
    logic            flush_i;
    logic            mem_req_valid_o;
    logic [31:0]     mem_req_addr_o;
    logic            mem_req_ready_i;
    logic            mem_resp_valid_i;
    logic [BW-1:0]   mem_resp_data_i;
    logic            bram_cmd_en_o;
    logic            bram_wr_en_o;
    logic [IW-1:0]   bram_addr_o;
    logic [TW+BW-1:0] bram_data_o;
    logic [TW+BW-1:0] bram_data_i;
    logic            busy_o;

    icache_controller #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .BLOCK_WIDTH(BW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o), .resp_instr_o(resp_instr_o), .flush_i(flush_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i(mem_resp_data_i),
        .bram_cmd_en_o(bram_cmd_en_o), .bram_wr_en_o(bram_wr_en_o), .bram_addr_o(bram_addr_o),
        .bram_data_o(bram_data_o), .bram_data_i(bram_data_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic [31:0]   word;
        logic [BW-1:0] line;
        bit            hit;
        int            lat;
        int            acc;
        int            mreq0;
    } sb_t;

    typedef struct {
        logic [31:0]   la;
        logic [BW-1:0] line;
        int            rd;
        int            dd;
    } mq_t;

    sb_t sb[$];
    mq_t mq[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int mreq_cnt = 0;
    bit auto_mem = 1'b1;
    int unsigned seed;

    // reference model: per-line valid flag and tag, plus a deferred flush
    bit            mvalid[256];
    logic [TW-1:0] mtag[256];
    bit            flush_flag = 1'b0;

    logic [TW+BW-1:0] bram[256];

    always @(posedge clk) cyc <= cyc + 1;

    // single-port BRAM: one-cycle read latency, write on enable with write select
    always @(posedge clk) begin
        if (bram_cmd_en_o) begin
            if (bram_wr_en_o) bram[bram_addr_o] <= bram_data_o;
            else              bram_data_i <= bram[bram_addr_o];
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // backing memory contents: fixed per line address
    function automatic logic [BW-1:0] mem_line(input logic [31:0] la);
        logic [BW-1:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*32 +: 32] = (la * 32'h9E3779B1) + ((w + 1) * 32'h7F4A7C15) ^ seed;
        end
        if (la == 32'h0000_1000) l[63:32] = 32'hDEADBEEF;
        return l;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        flush_flag = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input int rd, input int dd, output int acc);
        sb_t e;
        mq_t m;
        int budget;
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        #1;
        budget = 0;
        while (!req_ready_o && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!req_ready_o) begin
            chk("req_ready_timeout", 256'(req_ready_o), 256'(1));
            req_valid_i = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (flush_flag) model_clear();
        idx     = a[11:4];
        tag     = a[31:12];
        e.addr  = a;
        e.line  = mem_line({a[31:4], 4'h0});
        e.word  = e.line[a[3:2]*32 +: 32];
        e.hit   = mvalid[idx] && (mtag[idx] == tag);
        e.lat   = e.hit ? 1 : 4 + rd + dd;
        e.acc   = acc;
        e.mreq0 = mreq_cnt;
        sb.push_back(e);
        if (!e.hit) begin
            m.la = {a[31:4], 4'h0};
            m.line = e.line;
            m.rd = rd;
            m.dd = dd;
            mq.push_back(m);
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        if (!busy_o) chk("ready_during_flush", 256'(req_ready_o), 256'(0));
        flush_flag = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 256'({req_ready_o, resp_valid_o, resp_instr_o, mem_req_valid_o, mem_req_addr_o,
                        bram_cmd_en_o, bram_wr_en_o, bram_addr_o, bram_data_o, busy_o}), 256'(0));
    endtask

    task automatic drain();
        int budget = 0;
        while (sb.size() != 0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_outstanding", 256'(sb.size()), 256'(0));
    endtask

    // monitor: pops the scoreboard on each response, checks refill writes
    always @(negedge clk) begin
        if (rst_ni) begin
            if (bram_wr_en_o) begin
                if (sb.size() == 0) fail_event("unexpected_bram_write");
                else begin
                    chk("refill_cmd_en", 256'(bram_cmd_en_o), 256'(1));
                    chk("refill_is_miss", 256'(sb[0].hit), 256'(0));
                    chk("refill_index", 256'(bram_addr_o), 256'(sb[0].addr[11:4]));
                    chk("refill_word", 256'(bram_data_o), 256'({sb[0].addr[31:12], sb[0].line}));
                end
            end
            if (resp_valid_o) begin
                if (sb.size() == 0) fail_event("unexpected_resp");
                else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("resp_instr", 256'(resp_instr_o), 256'(e.word));
                    chk("resp_latency", 256'(cyc - e.acc), 256'(e.lat));
                    chk("mem_req_count", 256'(mreq_cnt - e.mreq0), 256'(e.hit ? 0 : 1));
                end
            end
        end
    end

    // memory responder: holds ready low rd cycles, responds dd cycles after handshake,
    // and injects stray response strobes while no fill is being waited for
    initial begin
        mq_t m;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        forever begin
            @(negedge clk);
            if (auto_mem) begin
                mem_resp_valid_i = 1'b0;
                if (rst_ni && mem_req_valid_o) begin
                    if (mq.size() == 0) fail_event("unexpected_mem_req");
                    else begin
                        m = mq.pop_front();
                        chk("mem_req_addr", 256'(mem_req_addr_o), 256'(m.la));
                        for (int i = 0; i < m.rd; i++) begin
                            @(negedge clk);
                            chk("mem_req_stable", 256'({mem_req_valid_o, mem_req_addr_o}),
                                256'({1'b1, m.la}));
                        end
                        mem_req_ready_i = 1'b1;
                        @(negedge clk);
                        mem_req_ready_i = 1'b0;
                        mreq_cnt++;
                        for (int i = 0; i < m.dd; i++) @(negedge clk);
                        mem_resp_valid_i = 1'b1;
                        mem_resp_data_i  = m.line;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    mem_resp_valid_i = 1'b1;
                    mem_resp_data_i  = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        int a0, a1, acc;
        int stray;
        int budget;
        seed = $urandom;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        flush_i     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bram[i] <= {20'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom};
            mtag[i] = '0;
        end
        model_clear();

        // reset: every output low
        repeat (3) begin
            @(negedge clk);
            check_all_zero("outputs_in_reset");
        end
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 256'({req_ready_o, busy_o}), 256'(2'b10));

        // cold miss, fill line 0x1000 with word1 = DEADBEEF
        issue(32'h0000_1004, 0, 0, acc);
        drain();
        // hits on the same line, back to back
        issue(32'h0000_1008, 0, 0, a0);
        issue(32'h0000_100C, 0, 0, a1);
        chk("hit_throughput", 256'(a1 - a0), 256'(2));
        drain();
        // conflicting tag on index 0 replaces the line
        issue(32'h0000_2004, 0, 0, acc);
        issue(32'h0000_1004, 0, 0, acc);
        drain();
        // memory holds ready low for 5 cycles
        issue(32'h0000_3010, 5, 0, acc);
        drain();

        // flush while waiting for fill data
        issue(32'h0000_4020, 0, 3, acc);
        wait_cyc(acc + 4);
        chk("flush_in_miss_wait_busy", 256'(busy_o), 256'(1));
        flush_i = 1'b1;
        flush_flag = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        wait_cyc(acc + 8);
        chk("flush_fill_completed", 256'(sb.size()), 256'(0));
        chk("ready_in_flush_idle", 256'({req_ready_o, busy_o}), 256'(0));
        @(negedge clk);
        chk("ready_after_flush", 256'(req_ready_o), 256'(1));
        issue(32'h0000_4020, 0, 0, acc);
        drain();

        // reset while waiting for fill data, stray response afterwards
        auto_mem = 1'b0;
        mem_resp_valid_i = 1'b0;
        issue(32'h0000_5040, 0, 0, acc);
        budget = 0;
        while (!mem_req_valid_o && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("manual_mem_req", 256'(mem_req_valid_o), 256'(1));
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        chk("in_miss_wait", 256'({busy_o, mem_req_valid_o}), 256'(2'b10));
        rst_ni = 1'b0;
        sb.delete();
        mq.delete();
        model_clear();
        repeat (2) begin
            @(negedge clk);
            check_all_zero("outputs_in_midmiss_reset");
        end
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_midmiss_reset", 256'(req_ready_o), 256'(1));
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = {4{32'hBAD0BAD0}};
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            mem_resp_valid_i = 1'b0;
            if (resp_valid_o || bram_cmd_en_o || busy_o) stray++;
        end
        chk("no_activity_after_stray", 256'(stray), 256'(0));
        auto_mem = 1'b1;

        // randomized traffic over a small tag/index pool so hits and conflicts both occur
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            logic [7:0] idx;
            int rd, dd;
            idx = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            a = {20'($urandom_range(0, 3)), idx, 2'($urandom), 2'($urandom)};
            rd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            dd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            issue(a, rd, dd, acc);
            if ($urandom_range(0, 19) == 0) do_flush();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
